half_predict_sequencer: RTL and testbench

Stream-side driver for the half-precision two-layer predict datapath. It fills the `x`, `W1`, `b1`, `W2` and `b2` parameter arrays from a single 16-bit valid/ready input stream and pulses `start`. It then waits for the predictor's `done` and returns the `y` vector as a 16-bit valid/ready output stream. It sits between the host DMA/stream fabric and the predict core, and is the producer/consumer at the other end of the core's array interface.

---
 rtl/half_predict_seq_pkg.sv | 26 ++
 rtl/half_argmax_tracker.sv | 80 ++++++++
 rtl/half_predict_sequencer.sv | 159 +++++++++++++++
 tb/tb_half_predict_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/half_predict_seq_pkg.sv
// Shared types and helpers for the half-precision predict sequencer.
// Optional argmax tracking is enabled with HALF_PREDICT_SEQ_ARGMAX_EN.
package half_predict_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    function automatic int frame_len(input int l1, input int l2, input int on);
        return l1 + l1 * l2 + l2 + l2 * on + on;
    endfunction

    // Monotonic unsigned key for IEEE half: negatives are bit-inverted so
    // larger magnitude sorts lower, positives get the top bit set.
    function automatic logic [15:0] half_order_key(input logic [15:0] h);
        return h[15] ? ~h : (h | 16'h8000);
    endfunction

    function automatic logic half_is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/half_argmax_tracker.sv
// Running argmax over a half-precision output stream; present only when
// HALF_PREDICT_SEQ_ARGMAX_EN is defined.
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
module half_argmax_tracker
    import half_predict_seq_pkg::*;
#(
    parameter int OUTPUT_NODES = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     data,
    input  logic                            fire,
    input  logic                            last,
    output logic [$clog2(OUTPUT_NODES)-1:0] class_idx,
    output logic                            class_valid
);
    localparam int IW = $clog2(OUTPUT_NODES);

    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [15:0]   best_key_q, best_key_d;
    logic          have_q, have_d;
    logic [IW-1:0] class_idx_q, class_idx_d;
    logic          class_valid_q, class_valid_d;
    logic [15:0]   key;
    logic          better;

    // Strict greater-than keeps ties on the earlier index; NaN never wins.
    assign key    = half_order_key(data);
    assign better = !half_is_nan(data) && (!have_q || (key > best_key_q));

    always_comb begin
        cnt_d         = cnt_q;
        best_idx_d    = best_idx_q;
        best_key_d    = best_key_q;
        have_d        = have_q;
        class_idx_d   = class_idx_q;
        class_valid_d = 1'b0;
        if (fire) begin
            if (last) begin
                class_idx_d   = better ? cnt_q : best_idx_q;
                class_valid_d = 1'b1;
                cnt_d         = '0;
                best_idx_d    = '0;
                best_key_d    = '0;
                have_d        = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (better) begin
                    best_idx_d = cnt_q;
                    best_key_d = key;
                    have_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            best_idx_q    <= '0;
            best_key_q    <= '0;
            have_q        <= 1'b0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            best_idx_q    <= best_idx_d;
            best_key_q    <= best_key_d;
            have_q        <= have_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
        end
    end

    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;

endmodule
`endif

// File: rtl/half_predict_sequencer.sv
// Loads predict-core parameter arrays from a 16-bit stream, starts the core,
// and streams back y. HALF_PREDICT_SEQ_ARGMAX_EN adds class_idx/class_valid.
module half_predict_sequencer
    import half_predict_seq_pkg::*;
#(
    parameter int LAYER1_NEURONS = 10,
    parameter int LAYER2_NEURONS = 10,
    parameter int OUTPUT_NODES   = 10
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [15:0]                                      s_data,
    input  logic                                             s_valid,
    input  logic                                             s_last,
    output logic                                             s_ready,
    output logic [LAYER1_NEURONS-1:0][15:0]                  x,
    output logic [LAYER1_NEURONS-1:0][LAYER2_NEURONS-1:0][15:0] W1,
    output logic [LAYER2_NEURONS-1:0][15:0]                  b1,
    output logic [LAYER2_NEURONS-1:0][OUTPUT_NODES-1:0][15:0] W2,
    output logic [OUTPUT_NODES-1:0][15:0]                    b2,
    output logic                                             start,
    input  logic                                             done,
    input  logic [OUTPUT_NODES-1:0][15:0]                    y,
    output logic [15:0]                                      m_data,
    output logic                                             m_valid,
    output logic                                             m_last,
    input  logic                                             m_ready,
    output logic                                             frame_err
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
    ,
    output logic [$clog2(OUTPUT_NODES)-1:0]                  class_idx,
    output logic                                             class_valid
`endif
);
    localparam int L1     = LAYER1_NEURONS;
    localparam int L2     = LAYER2_NEURONS;
    localparam int ON     = OUTPUT_NODES;
    localparam int N      = frame_len(L1, L2, ON);
    localparam int CW     = $clog2(N);
    localparam int IW     = $clog2(ON);
    localparam int OFF_W1 = L1;
    localparam int OFF_B1 = OFF_W1 + L1 * L2;
    localparam int OFF_W2 = OFF_B1 + L2;
    localparam int OFF_B2 = OFF_W2 + L2 * ON;

    state_e                  state_q, state_d;
    logic [N-1:0][15:0]      frame_q, frame_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [ON-1:0][15:0]     y_q, y_d;
    logic                    done_prev_q;
    logic                    frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        y_d         = y_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (s_valid) begin
                    frame_d[cnt_q] = s_data;
                    if (cnt_q == CW'(N - 1)) begin
                        // A frame of the right length is used even without s_last.
                        state_d     = ST_START;
                        cnt_d       = '0;
                        frame_err_d = !s_last;
                    end else if (s_last) begin
                        cnt_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // Edge detect: a done level held over from before WAIT is ignored.
                if (done && !done_prev_q) begin
                    y_d     = y;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_ready) begin
                    if (idx_q == IW'(ON - 1)) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            frame_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            y_q         <= '0;
            done_prev_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            done_prev_q <= done;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_ready   = (state_q == ST_LOAD);
    assign start     = (state_q == ST_START);
    assign m_valid   = (state_q == ST_SEND);
    assign m_last    = m_valid && (idx_q == IW'(ON - 1));
    assign m_data    = m_valid ? y_q[idx_q] : 16'h0000;
    assign frame_err = frame_err_q;

    for (genvar i = 0; i < L1; i++) begin : g_l1
        assign x[i] = frame_q[i];
        for (genvar j = 0; j < L2; j++) begin : g_w1
            assign W1[i][j] = frame_q[OFF_W1 + i * L2 + j];
        end
    end

    for (genvar i = 0; i < L2; i++) begin : g_l2
        assign b1[i] = frame_q[OFF_B1 + i];
        for (genvar j = 0; j < ON; j++) begin : g_w2
            assign W2[i][j] = frame_q[OFF_W2 + i * ON + j];
        end
    end

    for (genvar i = 0; i < ON; i++) begin : g_on
        assign b2[i] = frame_q[OFF_B2 + i];
    end

`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
    half_argmax_tracker #(
        .OUTPUT_NODES(ON)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .data        (m_data),
        .fire        (m_valid && m_ready),
        .last        (m_last),
        .class_idx   (class_idx),
        .class_valid (class_valid)
    );
`endif

endmodule

// File: tb/tb_half_predict_sequencer.sv
// Directed + randomized bench for half_predict_sequencer with a frame-slot
// model and a real-valued argmax model (argmax under HALF_PREDICT_SEQ_ARGMAX_EN).
module tb_half_predict_sequencer;
    localparam int L1 = 10;
    localparam int L2 = 10;
    localparam int ON = 10;
    localparam int N  = L1 + L1 * L2 + L2 + L2 * ON + ON;

    typedef logic [ON-1:0][15:0] yv_t;

    logic clk = 1'b0;
    logic rst, s_valid, s_last, s_ready, start, done, m_valid, m_last, m_ready, frame_err;
    logic [15:0] s_data, m_data;
    logic [L1-1:0][15:0]          x;
    logic [L1-1:0][L2-1:0][15:0]  W1;
    logic [L2-1:0][15:0]          b1;
    logic [L2-1:0][ON-1:0][15:0]  W2;
    logic [ON-1:0][15:0]          b2;
    yv_t y;
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
    logic [$clog2(ON)-1:0] class_idx;
    logic                  class_valid;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl [N];

    always #5 clk = ~clk;

    half_predict_sequencer #(
        .LAYER1_NEURONS(L1), .LAYER2_NEURONS(L2), .OUTPUT_NODES(ON)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .x(x), .W1(W1), .b1(b1), .W2(W2), .b2(b2), .start(start),
        .done(done), .y(y), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .frame_err(frame_err)
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
        , .class_idx(class_idx), .class_valid(class_valid)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic real half_to_real(input logic [15:0] h);
        real v;
        int e = int'(h[14:10]);
        int m = int'(h[9:0]);
        if (e == 0)       v = m * (2.0 ** -24);
        else if (e == 31) v = 1.0e30;
        else              v = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -v : v;
    endfunction

    // Largest real value wins; first occurrence on ties; +0 above -0; NaN skipped.
    function automatic int model_argmax(input yv_t v);
        int best = -1;
        real bv = 0.0;
        for (int k = 0; k < ON; k++) begin
            real cv;
            if (v[k][14:10] == 5'h1f && v[k][9:0] != 10'd0) continue;
            cv = half_to_real(v[k]);
            if (best < 0 || cv > bv ||
                (cv == bv && cv == 0.0 && !v[k][15] && v[best][15])) begin
                best = k;
                bv   = cv;
            end
        end
        return (best < 0) ? 0 : best;
    endfunction

    function automatic yv_t rand_y();
        yv_t v;
        for (int k = 0; k < ON; k++) begin
            case ($urandom_range(0, 5))
                0: v[k] = 16'h7C00 | 16'($urandom_range(1, 1023));
                1: v[k] = 16'h0000;
                2: v[k] = 16'h8000;
                3: v[k] = 16'h4000;
                4: v[k] = 16'hC000;
                default: v[k] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic chk_arrays(input string tag);
        for (int i = 0; i < L1; i++) begin
            chk({tag, "_x"}, x[i], mdl[i]);
            for (int j = 0; j < L2; j++) chk({tag, "_W1"}, W1[i][j], mdl[L1 + i * L2 + j]);
        end
        for (int i = 0; i < L2; i++) begin
            chk({tag, "_b1"}, b1[i], mdl[L1 + L1 * L2 + i]);
            for (int j = 0; j < ON; j++)
                chk({tag, "_W2"}, W2[i][j], mdl[L1 + L1 * L2 + L2 + i * ON + j]);
        end
        for (int i = 0; i < ON; i++) chk({tag, "_b2"}, b2[i], mdl[N - ON + i]);
    endtask

    // Sends words 0..stop_at, s_last on word last_at (-1: never).
    task automatic load_frame(input int stop_at, input int last_at, input bit idx_data, input bit gaps);
        int k = 0;
        bit ferr_exp = 1'b0;
        logic [15:0] w;
        while (k <= stop_at) begin
            chk("s_ready_load", s_ready, 1);
            chk("start_idle", start, 0);
            chk("frame_err_load", frame_err, ferr_exp);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                s_last  = 1'($urandom);
                ferr_exp = 1'b0;
            end else begin
                w = idx_data ? 16'(k) : 16'($urandom);
                s_valid = 1'b1;
                s_data  = w;
                s_last  = (k == last_at);
                mdl[k]  = w;
                ferr_exp = (k == last_at && k != N - 1) || (k == N - 1 && k != last_at);
                k++;
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("frame_err_end", frame_err, ferr_exp);
        if (stop_at == N - 1) begin
            chk("start_pulse", start, 1);
            chk("s_ready_start", s_ready, 0);
            step();
            chk("start_once", start, 0);
            chk("frame_err_clear", frame_err, 0);
        end else begin
            chk("start_none", start, 0);
            chk("s_ready_after_err", s_ready, 1);
            step();
            chk("frame_err_clear", frame_err, 0);
        end
    endtask

    task automatic fire_done(input yv_t v);
        done = 1'b0;
        step();
        chk("m_valid_wait", m_valid, 0);
        chk("start_wait", start, 0);
        y    = v;
        done = 1'b1;
        step();
        chk("m_valid_rise", m_valid, 1);
        y = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // mode 0: ready high, 1: toggle 1/0, 2: random
    task automatic drain(input yv_t v, input int mode);
        int n = 0;
        bit rdy;
        for (int c = 0; c < 200 && n < ON; c++) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            m_ready = rdy;
            chk("m_valid_send", m_valid, 1);
            chk("m_data", m_data, v[n]);
            chk("m_last", m_last, (n == ON - 1));
            chk("s_ready_send", s_ready, 0);
            step();
            if (rdy) n++;
        end
        m_ready = 1'b0;
        chk("drain_count", n, ON);
        chk("s_ready_back", s_ready, 1);
        chk("m_valid_off", m_valid, 0);
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
        chk("class_valid_pulse", class_valid, 1);
        chk("class_idx", class_idx, model_argmax(v));
        step();
        chk("class_valid_once", class_valid, 0);
        chk("class_idx_hold", class_idx, model_argmax(v));
`endif
    endtask

    initial begin
        yv_t v;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        done = 1'b0; y = '0; m_ready = 1'b0;
        for (int i = 0; i < N; i++) mdl[i] = 16'h0000;
        repeat (3) step();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk_arrays("rst");
        rst = 1'b0;
        step();

        // Index-valued frame; W1[2][3] sits at word 10 + 2*10 + 3.
        load_frame(N - 1, N - 1, 1'b1, 1'b0);
        chk("W1_2_3", W1[2][3], 16'd33);
        chk("b2_9", b2[9], 16'd229);
        chk_arrays("idx");
        repeat (3) begin
            chk("m_valid_nodone", m_valid, 0);
            step();
        end
        v = rand_y();
        fire_done(v);
        drain(v, 2);

        // Early s_last, then a clean frame loaded with done already high.
        load_frame(50, 50, 1'b0, 1'b1);
        done = 1'b1;
        load_frame(N - 1, N - 1, 1'b0, 1'b1);
        chk_arrays("refill");
        repeat (3) begin
            y = {$urandom, $urandom, $urandom, $urandom, $urandom};
            chk("m_valid_stale_done", m_valid, 0);
            step();
        end
        for (int k = 0; k < ON; k++) v[k] = 16'h3C00 + 16'(k);
        fire_done(v);
        drain(v, 1);

        // Missing s_last on the final word still starts; then reset mid-SEND.
        load_frame(N - 1, -1, 1'b0, 1'b1);
        chk_arrays("nolast");
        v = rand_y();
        fire_done(v);
        m_ready = 1'b1;
        repeat (4) step();
        chk("mid_send_data", m_data, v[4]);
        m_ready = 1'b0;
        rst = 1'b1;
        step();
        rst  = 1'b0;
        done = 1'b0;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_s_ready", s_ready, 1);
        chk("abort_m_data", m_data, 0);
        chk("abort_start", start, 0);
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
        chk("abort_class_idx", class_idx, 0);
        chk("abort_class_valid", class_valid, 0);
`endif
        for (int i = 0; i < N; i++) mdl[i] = 16'h0000;
        chk_arrays("abort");

        // Signed zeros, a NaN and a tie in the result vector.
        load_frame(N - 1, N - 1, 1'b0, 1'b1);
        v = {ON{16'hC000}};
        v[0] = 16'hBC00; v[1] = 16'h0000; v[2] = 16'h8000;
        v[3] = 16'h7E00; v[4] = 16'h4000; v[5] = 16'h4000;
        fire_done(v);
        drain(v, 0);
`ifdef HALF_PREDICT_SEQ_ARGMAX_EN
        chk("argmax_vec", class_idx, 4);
`endif

        for (int r = 0; r < 3; r++) begin
            load_frame(N - 1, N - 1, 1'b0, 1'b1);
            chk_arrays("rand");
            v = rand_y();
            fire_done(v);
            drain(v, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
